// File: rtl/video_timing_generator.sv
// video_timing_generator: parameterised raster timing with registered video outputs and graceful end-of-frame stop
module video_timing_generator #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int X_WIDTH   = 12,
  parameter int Y_WIDTH   = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               busy,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               frame_start,
  output logic               line_end
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [X_WIDTH-1:0] H_LAST = X_WIDTH'(H_TOTAL - 1);
  localparam logic [X_WIDTH-1:0] H_VIS  = X_WIDTH'(H_VISIBLE);
  localparam logic [X_WIDTH-1:0] H_SS   = X_WIDTH'(H_VISIBLE + H_FRONT);
  localparam logic [X_WIDTH-1:0] H_SE   = X_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [Y_WIDTH-1:0] V_LAST = Y_WIDTH'(V_TOTAL - 1);
  localparam logic [Y_WIDTH-1:0] V_VIS  = Y_WIDTH'(V_VISIBLE);
  localparam logic [Y_WIDTH-1:0] V_SS   = Y_WIDTH'(V_VISIBLE + V_FRONT);
  localparam logic [Y_WIDTH-1:0] V_SE   = Y_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t             state, state_n;
  logic [X_WIDTH-1:0] h, h_n;
  logic [Y_WIDTH-1:0] v, v_n;
  logic               run, h_last, v_last;

  assign run    = state != IDLE;
  assign busy   = run;
  assign h_last = h == H_LAST;
  assign v_last = v == V_LAST;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     state_n = enable ? RUN : IDLE;
      RUN:      state_n = enable ? RUN : STOPPING;
      STOPPING: state_n = enable ? RUN : (h_last && v_last) ? IDLE : STOPPING;
      default:  state_n = IDLE;
    endcase
    h_n = run ? (h_last ? '0 : h + 1'b1) : '0;
    v_n = run ? (h_last ? (v_last ? '0 : v + 1'b1) : v) : '0;
  end

  // Outputs describe the counter value held before this edge, giving latency 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      h           <= '0;
      v           <= '0;
      de          <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
    end else begin
      state       <= state_n;
      h           <= h_n;
      v           <= v_n;
      de          <= run && h < H_VIS && v < V_VIS;
      hsync       <= (run && h >= H_SS && h < H_SE) ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= (run && v >= V_SS && v < V_SE) ? VSYNC_POL : ~VSYNC_POL;
      x           <= run ? h : '0;
      y           <= run ? v : '0;
      frame_start <= run && h == '0 && v == '0;
      line_end    <= run && h_last;
    end
  end
endmodule

// File: tb/tb_video_timing_generator.sv
// tb_video_timing_generator: directed and random enable/reset stimulus against a linear pixel-index frame model
module tb_video_timing_generator;
  localparam int HV = 4, HF = 1, HS = 2, HB = 1;
  localparam int VV = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic        busy, de, hsync, vsync, frame_start, line_end;
  logic [11:0] x, y;

  int checks = 0, errors = 0;
  bit m_act, m_stop;
  int m_pos;

  always #5 clk = ~clk;

  video_timing_generator #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .X_WIDTH(12), .Y_WIDTH(12)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .busy(busy), .de(de),
    .hsync(hsync), .vsync(vsync), .x(x), .y(y),
    .frame_start(frame_start), .line_end(line_end)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected outputs for a cycle whose described pixel is pos (linear index) when act is set
  task automatic check_outputs(input string tag, input bit act, input int pos);
    int px, py;
    px = pos % HT;
    py = pos / HT;
    chk({tag, ":busy"}, busy, m_act);
    chk({tag, ":de"}, de, act && px < HV && py < VV);
    chk({tag, ":hsync"}, hsync, act && px >= HV + HF && px < HV + HF + HS);
    chk({tag, ":vsync"}, vsync, act && py >= VV + VF && py < VV + VF + VS);
    chk({tag, ":x"}, x, act ? px : 0);
    chk({tag, ":y"}, y, act ? py : 0);
    chk({tag, ":frame_start"}, frame_start, act && pos == 0);
    chk({tag, ":line_end"}, line_end, act && px == HT - 1);
  endtask

  task automatic step(input bit en);
    bit pa;
    int pp;
    enable = en;
    @(posedge clk);
    pa = m_act;
    pp = m_pos;
    if (!m_act) begin
      if (en) begin
        m_act = 1; m_stop = 0; m_pos = 0;
      end
    end else begin
      if (m_pos == FT - 1 && m_stop && !en) m_act = 0;
      m_stop = !en;
      m_pos = (m_pos + 1) % FT;
    end
    #1;
    check_outputs("step", pa, pp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    m_act = 0; m_stop = 0; m_pos = 0;
    check_outputs("reset", 0, 0);
    @(posedge clk);
    #1;
    check_outputs("reset_hold", 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    int n, de_sum, fs_cnt;
    bit en;
    reset = 1'b1;
    enable = 1'b0;
    m_act = 0; m_stop = 0; m_pos = 0;
    #12;
    check_outputs("por", 0, 0);
    reset = 1'b0;

    // Continuous run: frame period, de duty, sync placement
    step(1);
    n = 0;
    while (!frame_start && n < 100) begin step(1); n++; end
    chk("A_first_fs", frame_start, 1);
    de_sum = 0; fs_cnt = 0;
    repeat (2 * FT) begin step(1); de_sum += int'(de); fs_cnt += int'(frame_start); end
    chk("A_de_per_2frames", de_sum, 2 * HV * VV);
    chk("A_fs_per_2frames", fs_cnt, 2);

    // Drop enable at y=1: frame finishes, then idle
    n = 0;
    while (y != 1 && n < 100) begin step(1); n++; end
    chk("B_wait_y1", y, 1);
    step(0);
    n = 0;
    while (busy && n < 100) begin step(0); n++; end
    chk("B_busy_fall", busy, 0);
    chk("B_last_x", x, HT - 1);
    chk("B_last_y", y, VT - 1);
    fs_cnt = 0;
    repeat (10) begin step(0); fs_cnt += int'(frame_start); end
    chk("B_no_fs", fs_cnt, 0);

    // Drop at y=2, raise at y=3: period unchanged
    n = 0;
    while (!frame_start && n < 100) begin step(1); n++; end
    chk("C_fs_seen", frame_start, 1);
    n = 0;
    while (y != 2 && n < 100) begin step(1); n++; end
    while (y != 3 && n < 100) begin step(0); n++; end
    do begin step(1); n++; end while (!frame_start && n < 100);
    chk("C_period", n, FT);

    // Reset mid-frame at x=2,y=1
    n = 0;
    while (!(x == 2 && y == 1) && n < 100) begin step(1); n++; end
    chk("D_wait_x2y1", {x[3:0], y[3:0]}, {4'd2, 4'd1});
    do_reset();
    step(1);
    chk("D_fs_edge1", frame_start, 0);
    step(1);
    chk("D_fs_edge2", frame_start, 1);

    // Single-clock enable pulse gives exactly one frame
    do_reset();
    step(0);
    step(0);
    step(1);
    n = int'(busy);
    fs_cnt = 0;
    while (busy && fs_cnt < 200) begin step(0); n += int'(busy); fs_cnt++; end
    chk("E_busy_len", n, FT);
    repeat (4) step(0);

    // Random enable with occasional reset
    en = 1;
    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) en = !en;
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(en);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
